// File: rtl/gf_clmul_seq_pkg.sv
// gf_pkg: shared types, defaults and helpers for the GF(2^m) datapath stages.
package gf_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} gf_state_t;
    localparam int GF_DATA_WIDTH_DEF = 10;
    localparam int GF_GRADE_W = $clog2(GF_DATA_WIDTH_DEF) + 1;
    function automatic logic [63:0] mask_by_grade(input int grade);
        return (grade >= 64) ? '1 : (64'(1) << grade) - 64'(1);
    endfunction
endpackage

// File: rtl/gf_clmul_seq_if.sv
// gf_clmul_seq_if: operand/product handshake bundle between producer, multiplier and reducer.
interface gf_clmul_seq_if #(parameter int DATA_WIDTH = gf_pkg::GF_DATA_WIDTH_DEF);
    localparam int GW = $clog2(DATA_WIDTH) + 1;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [DATA_WIDTH-1:0] a_in, b_in;
    logic [GW-1:0] polyn_grade_in, polyn_grade_out;
    logic [DATA_WIDTH:0] polyn_red_in, polyn_red_out;
    logic [2*DATA_WIDTH-1:0] prod_out;
    modport slave (
        input in_valid, a_in, b_in, polyn_grade_in, polyn_red_in, out_ready,
        output in_ready, out_valid, prod_out, polyn_grade_out, polyn_red_out
    );
    modport master (
        output in_valid, a_in, b_in, polyn_grade_in, polyn_red_in, out_ready,
        input in_ready, out_valid, prod_out, polyn_grade_out, polyn_red_out
    );
endinterface

// File: rtl/gf_clmul_seq_step.sv
// gf_clmul_step: one carry-less multiply-accumulate step.
module gf_clmul_step #(parameter int WIDTH = 20) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a_sh,
    input  logic             b_bit,
    output logic [WIDTH-1:0] res
);
    assign res = acc ^ (b_bit ? a_sh : '0);
endmodule

// File: rtl/gf_clmul_seq.sv
// gf_clmul_seq: iterative carry-less multiplier, one multiplier bit per clock.
module gf_clmul_seq
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = GF_DATA_WIDTH_DEF
) (
    input logic clk,
    input logic rst,
    gf_clmul_seq_if.slave bus
);
    localparam int GW = $clog2(DATA_WIDTH) + 1;
    localparam int PW = 2 * DATA_WIDTH;
    gf_state_t state, state_n;
    logic [GW-1:0] cnt, grade_q;
    logic [DATA_WIDTH:0] red_q;
    logic [PW-1:0] acc, a_sh, acc_n;
    logic [DATA_WIDTH-1:0] b_sh, mask;
    logic accept, grade_ok, last;

    assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;
    assign grade_ok = bus.polyn_grade_in >= GW'(2) && bus.polyn_grade_in <= GW'(DATA_WIDTH);
    assign last = cnt == grade_q - GW'(1);
    assign mask = DATA_WIDTH'(mask_by_grade(int'(bus.polyn_grade_in)));
    assign bus.out_valid = state == DONE;
    assign bus.prod_out = acc;
    assign bus.polyn_grade_out = grade_q;
    assign bus.polyn_red_out = red_q;

    gf_clmul_step #(.WIDTH(PW)) u_step (.acc(acc), .a_sh(a_sh), .b_bit(b_sh[0]), .res(acc_n));

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    // An invalid grade skips BUSY; acc is already cleared on accept, so the product is 0.
    always_comb begin
        state_n = state;
        state_n = accept ? (grade_ok ? BUSY : DONE) :
                  (state == BUSY && last) ? DONE :
                  (state == DONE && bus.out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            grade_q <= '0;
            red_q   <= '0;
        end else if (accept) begin
            cnt     <= '0;
            acc     <= '0;
            a_sh    <= {{DATA_WIDTH{1'b0}}, bus.a_in & mask};
            b_sh    <= bus.b_in & mask;
            grade_q <= bus.polyn_grade_in;
            red_q   <= bus.polyn_red_in;
        end else if (state == BUSY) begin
            acc  <= acc_n;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + GW'(1);
        end
    end
endmodule

// File: doc/gf_clmul_seq.md
Name: gf_clmul_seq

Overview:
- Iterative carry-less (GF(2)[x]) multiplier, one operand bit per clock.
- Sits directly upstream of the GF(2^m) reduction stage and produces its unreduced 2*DATA_WIDTH-bit product.
- Forwards polyn_grade and the primitive polynomial alongside the product, so the reducer is fed from one registered bundle.
- Valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 10, maximum field degree m; operand width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle.
- a_in  in  DATA_WIDTH  multiplicand polynomial, bit k = coefficient of x^k.
- b_in  in  DATA_WIDTH  multiplier polynomial.
- polyn_grade_in  in  $clog2(DATA_WIDTH)+1  field degree m.
- polyn_red_in  in  DATA_WIDTH+1  primitive polynomial; carried through, not used here.
- out_valid  out  1  product bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- prod_out  out  2*DATA_WIDTH  unreduced carry-less product; bit 2*DATA_WIDTH-1 is always 0.
- polyn_grade_out  out  $clog2(DATA_WIDTH)+1  registered copy of grade.
- polyn_red_out  out  DATA_WIDTH+1  registered copy of the primitive polynomial.

Behaviour:
- Reset values: all outputs 0 except in_ready, which is 1. State goes to IDLE; cnt, acc, a_sh and b_sh are cleared.
- Reset is checked before all other events. Reset mid-BUSY or in DONE discards the operation with no output.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept happens on in_valid & in_ready.
- On accept:
  - a_sh and b_sh get the operands with bits at index >= grade cleared.
  - acc <= 0, cnt <= 0.
  - grade and the primitive polynomial are latched.
- States:
  - IDLE: on accept, go to BUSY if 2 <= grade <= DATA_WIDTH; otherwise go to DONE with acc = 0 (invalid grade gives product 0, matching the reducer).
  - BUSY: each cycle
    - acc ^= b_sh[0] ? a_sh : 0, where a_sh is 2*DATA_WIDTH wide;
    - a_sh <<= 1, b_sh >>= 1, cnt++.
    - When cnt == grade-1 in the current cycle, go to DONE.
    - Accepts nothing.
  - DONE: out_valid = 1.
    - prod_out = acc, with polyn_grade_out and polyn_red_out, all held stable until out_ready.
    - If out_ready & in_valid: load the new bundle in the same cycle and go to BUSY, or back to DONE for an invalid grade. out_valid stays 1 only in that invalid-grade case.
    - If out_ready & !in_valid: go to IDLE.
- Latency, bundle accepted at edge T:
  - valid grade m: out_valid asserted after edge T+m, i.e. m BUSY cycles.
  - invalid grade: out_valid asserted after edge T+1.
- Throughput: one result per m+1 cycles with continuous traffic.
- Iteration count is fixed by grade; there is no early exit on b_sh == 0, so latency is deterministic.
- Arithmetic is XOR only, with no carries. For valid grade the max product degree is 2m-2, so bits >= 2m-1 of prod_out are 0.
- Inputs are sampled only on the accept edge; changes at other times are ignored.
- out_valid never drops without out_ready while not in reset.

Decomposition:
- Shared package gf_pkg holds:
  - the state enum {IDLE, BUSY, DONE};
  - GF_DATA_WIDTH_DEF = 10;
  - grade-width localparam $clog2(DATA_WIDTH)+1;
  - a constant-function operand mask mask_by_grade(grade).
  The reducer uses the same grade width.
- One natural sub-module, gf_clmul_step: combinational, (acc, a_sh, b_bit) -> acc ^ (b_bit ? a_sh : 0). Reusable by a future unrolled variant.

Test Plan:
- grade=4, a=0xB, b=0x6, out_ready=1 -> prod_out=0x3A; out_valid 4 cycles after accept, high for 1 cycle; polyn_grade_out=4.
- grade=10, a=0x3FF, b=0x3FF -> prod_out=0x55555 after 10 BUSY cycles; in_ready=0 throughout BUSY.
- Masking: grade=4, a=0x3F3, b=0x3F1 -> operands used are 0x3 and 0x1; prod_out=0x003.
- grade=1, and grade=0, any a/b -> prod_out=0, out_valid one cycle after accept.
- Backpressure then chaining: result 0x3A with out_ready=0 for 3 cycles -> prod_out and out_valid held, in_ready=0. Then out_ready=1 with in_valid=1 (grade=4, a=0x1, b=0x1) in the same cycle -> new bundle accepted; next prod_out=0x001 four cycles later.
- Reset asserted in the 2nd BUSY cycle of a grade=10 operation -> next cycle IDLE, out_valid=0, in_ready=1. A following grade=4, a=0xB, b=0x6 still yields 0x3A.
